// File: rtl/zap_wb_pkg.sv
// Shared definitions for the Wishbone FIFO drain: FIFO entry layout, CTI codes and FSM encoding.
package zap_wb_pkg;

  localparam int unsigned ENTRY_W     = 69;
  localparam int unsigned ENT_WE_BIT  = 68;
  localparam int unsigned ENT_SEL_LSB = 64;
  localparam int unsigned ENT_ADR_LSB = 32;
  localparam int unsigned ENT_DAT_LSB = 0;

  // Every transfer is a single classic cycle, so CTI always reports end-of-burst.
  localparam logic [2:0] CTI_EOB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_RETRY = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } entry_t;

endpackage

// File: rtl/zap_wb_timer.sv
// Saturating bus-cycle timeout counter; o_expired marks the LIMIT-th consecutive enabled cycle.
module zap_wb_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW:0] LIMIT_W = LIMIT[CW:0];
  localparam logic [CW:0] ONE_W   = {{CW{1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != LIMIT_W[CW-1:0])) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed cycles, so the current cycle is number cnt_q+1.
  assign o_expired = i_en && (({1'b0, cnt_q} + ONE_W) >= LIMIT_W);

endmodule

// File: rtl/zap_wb_fifo_drain.sv
// Drains a FWFT FIFO of write/read requests into single Wishbone B3 classic cycles.
// Define ZAP_WB_ERR_RETRY_EN to reissue an entry up to MAX_RETRY times after i_wb_err.
module zap_wb_fifo_drain
  import zap_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [ENTRY_W-1:0] i_fifo_data,
  input  logic               i_fifo_empty_n,
  output logic               o_fifo_ack,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  output logic               o_wb_we,
  output logic [3:0]         o_wb_sel,
  output logic [31:0]        o_wb_adr,
  output logic [31:0]        o_wb_dat,
  output logic [2:0]         o_wb_cti,
  input  logic               i_wb_ack,
  input  logic               i_wb_err,
  input  logic [31:0]        i_wb_dat,
  output logic [31:0]        o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_err,
  input  logic               i_err_clr
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be within 1..65535");
  end
  if (MAX_RETRY > 65535) begin : g_bad_retry
    $error("MAX_RETRY must be within 0..65535");
  end

  state_e      state_q, state_d;
  entry_t      entry_q, entry_d;
  entry_t      head;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;
  logic        err_set;
  logic        pop;
  logic        expired;

`ifdef ZAP_WB_ERR_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAX_RETRY_W = MAX_RETRY[RW-1:0];
  logic [RW-1:0] retry_q, retry_d;
`endif

  always_comb begin
    head.we  = i_fifo_data[ENT_WE_BIT];
    head.sel = i_fifo_data[ENT_SEL_LSB +: 4];
    head.adr = i_fifo_data[ENT_ADR_LSB +: 32];
    head.dat = i_fifo_data[ENT_DAT_LSB +: 32];
  end

  // The timer is held clear outside BUS, so each attempt starts counting from zero.
  zap_wb_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (state_q != S_BUS),
    .i_en      (state_q == S_BUS),
    .o_expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_set    = 1'b0;
    pop        = 1'b0;
`ifdef ZAP_WB_ERR_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_fifo_empty_n) begin
          pop     = 1'b1;
          entry_d = head;
          state_d = S_BUS;
`ifdef ZAP_WB_ERR_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      S_BUS: begin
        if (i_wb_ack) begin
          state_d = S_IDLE;
          if (!entry_q.we) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i_wb_dat;
          end
        end else if (i_wb_err) begin
`ifdef ZAP_WB_ERR_RETRY_EN
          if (retry_q < MAX_RETRY_W) begin
            state_d = S_RETRY;
            retry_d = retry_q + {{(RW-1){1'b0}}, 1'b1};
          end else begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end
`else
          state_d = S_IDLE;
          err_set = 1'b1;
`endif
        end else if (expired) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end
      end
      S_RETRY: begin
        state_d = S_BUS;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A set in the same cycle as a clear must win so no error is ever lost.
  assign err_d = err_set | (err_q & ~i_err_clr);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

`ifdef ZAP_WB_ERR_RETRY_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // Handshake: the FIFO head is consumed on a rising edge where o_fifo_ack=1;
  // a Wishbone cycle completes on the edge where cyc/stb=1 and ack, err or timeout.
  assign o_fifo_ack = pop & i_reset_n;
  assign o_wb_cyc   = (state_q == S_BUS);
  assign o_wb_stb   = (state_q == S_BUS);
  assign o_wb_we    = entry_q.we;
  assign o_wb_sel   = entry_q.sel;
  assign o_wb_adr   = entry_q.adr;
  assign o_wb_dat   = entry_q.dat;
  assign o_wb_cti   = CTI_EOB;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_err      = err_q;

endmodule

// File: tb/tb_zap_wb_fifo_drain.sv
// Bench for zap_wb_fifo_drain: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_zap_wb_fifo_drain;

  localparam int unsigned TO = 4;
  localparam int unsigned MR = 2;
`ifdef ZAP_WB_ERR_RETRY_EN
  localparam int ERR_STARTS = 6;
`else
  localparam int ERR_STARTS = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [68:0] fifo_data = '0;
  logic        fifo_empty_n = 1'b0;
  logic        fifo_ack;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_o;
  logic [2:0]  wb_cti;
  logic        wb_ack = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] rd_data;
  logic        rd_valid, busy, err;
  logic        err_clr = 1'b0;

  zap_wb_fifo_drain #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_fifo_data(fifo_data), .i_fifo_empty_n(fifo_empty_n),
    .o_fifo_ack(fifo_ack), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_sel(wb_sel), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat_o), .o_wb_cti(wb_cti),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_dat_i), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .o_busy(busy), .o_err(err), .i_err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stimulus controls, applied at the next falling edge
  logic        nx_rst_n = 1'b0;
  logic        nx_clr = 1'b0;
  int          mode = 0;   // 0 silent, 1 ack, 2 err, 3 ack+err, 4 random
  int          delay = 0;
  int          s_cnt = 0;
  logic [31:0] s_rdat = '0;
  bit          rand_gap = 1'b0;
  logic [68:0] exp_q[$];   // bench FIFO contents, head at index 0

  // Reference model (transaction level)
  bit          m_busy = 1'b0, m_retry_wait = 1'b0, m_err = 1'b0, m_rdv = 1'b0;
  logic [68:0] m_ent = '0;
  logic [31:0] m_rdd = '0;
  int          m_waits = 0, m_tries = 0;

  // Observed DUT activity for literal checks
  int          n_pop = 0, n_cyc = 0, n_starts = 0, n_rdv = 0;
  logic [31:0] last_rdd = '0, first_adr = '0, first_dat = '0;
  bit          prev_cyc = 1'b0;

  int          n_checks = 0, n_fail = 0;

  function automatic logic [68:0] mk(input logic we, input logic [3:0] sel,
                                     input logic [31:0] adr, input logic [31:0] dat);
    return {we, sel, adr, dat};
  endfunction

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit idle;
    idle = !m_busy && !m_retry_wait;
    check("fifo_ack", {68'd0, fifo_ack}, {68'd0, rst_n && idle && fifo_empty_n});
    check("cyc", {68'd0, wb_cyc}, {68'd0, m_busy});
    check("stb", {68'd0, wb_stb}, {68'd0, m_busy});
    check("cti", {66'd0, wb_cti}, {66'd0, 3'b111});
    check("busy", {68'd0, busy}, {68'd0, !idle});
    check("err", {68'd0, err}, {68'd0, m_err});
    check("rd_valid", {68'd0, rd_valid}, {68'd0, m_rdv});
    check("rd_data", {37'd0, rd_data}, {37'd0, m_rdd});
    if (m_busy) check("bus_entry", {wb_we, wb_sel, wb_adr, wb_dat_o}, m_ent);
  endtask

  task automatic advance();
    bit idle, set_err;
    idle = !m_busy && !m_retry_wait;
    set_err = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_retry_wait = 0; m_err = 0; m_rdv = 0;
      m_ent = '0; m_rdd = '0; m_waits = 0; m_tries = 0;
    end else begin
      m_rdv = 0;
      if (idle) begin
        if (fifo_empty_n) begin
          m_ent = exp_q.pop_front();
          m_busy = 1; m_waits = 0; m_tries = 0;
        end
      end else if (m_retry_wait) begin
        m_retry_wait = 0; m_busy = 1; m_waits = 0;
      end else begin
        m_waits++;
        if (wb_ack) begin
          m_busy = 0;
          if (!m_ent[68]) begin
            m_rdv = 1; m_rdd = wb_dat_i;
          end
        end else if (wb_err) begin
          m_busy = 0;
`ifdef ZAP_WB_ERR_RETRY_EN
          if (m_tries < MR) begin
            m_tries++; m_retry_wait = 1;
          end else set_err = 1;
`else
          set_err = 1;
`endif
        end else if (m_waits == TO) begin
          m_busy = 0; set_err = 1;
        end
      end
      if (set_err) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  endtask

  task automatic cycle();
    int r;
    @(negedge clk);
    rst_n = nx_rst_n;
    err_clr = nx_clr;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_dat_i = $urandom;
    if (wb_cyc) begin
      case (mode)
        1: begin wb_ack = (s_cnt == delay); wb_dat_i = s_rdat; end
        2: wb_err = (s_cnt == delay);
        3: begin wb_ack = (s_cnt == delay); wb_err = (s_cnt == delay); end
        4: begin
          r = $urandom_range(0, 99);
          wb_ack = (r < 35) || (r >= 95);
          wb_err = (r >= 35 && r < 50) || (r >= 95);
        end
        default: ;
      endcase
      s_cnt++;
    end else begin
      s_cnt = 0;
    end
    fifo_empty_n = (exp_q.size() > 0) && !(rand_gap && $urandom_range(0, 3) == 0);
    if (exp_q.size() > 0) fifo_data = exp_q[0];
    else fifo_data = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom};
    #1;
    compare();
    advance();
    if (fifo_ack) n_pop++;
    if (wb_cyc) n_cyc++;
    if (wb_cyc && !prev_cyc) begin
      n_starts++;
      if (n_starts == 1) begin first_adr = wb_adr; first_dat = wb_dat_o; end
    end
    prev_cyc = wb_cyc;
    if (rd_valid) begin n_rdv++; last_rdd = rd_data; end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clr_mon();
    n_pop = 0; n_cyc = 0; n_starts = 0; n_rdv = 0;
  endtask

  initial begin
    int waited;
    // Reset holds off popping even with a valid head
    exp_q.push_back(mk(1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF));
    run(3);
    check_int("reset_no_pop", n_pop, 0);
    check("reset_cyc", {68'd0, wb_cyc}, 69'd0);
    check("reset_busy", {68'd0, busy}, 69'd0);
    check("reset_rd_data", {37'd0, rd_data}, 69'd0);

    // Single write, ack three cycles after stb
    nx_rst_n = 1'b1; mode = 1; delay = 3;
    run(10);
    check_int("wr_pops", n_pop, 1);
    check_int("wr_starts", n_starts, 1);
    check_int("wr_cyc_cycles", n_cyc, 4);
    check("wr_adr", {37'd0, first_adr}, 69'h1000);
    check("wr_dat", {37'd0, first_dat}, 69'hDEAD_BEEF);
    check("wr_err", {68'd0, err}, 69'd0);
    check_int("wr_no_rdv", n_rdv, 0);

    // Single read returns slave data
    clr_mon(); delay = 1; s_rdat = 32'h1234_5678;
    exp_q.push_back(mk(1'b0, 4'hF, 32'h2000, 32'h0));
    run(8);
    check_int("rd_valid_count", n_rdv, 1);
    check("rd_value", {37'd0, last_rdd}, 69'h1234_5678);

    // Silent slave: timeout after exactly TO cycles
    clr_mon(); mode = 0;
    exp_q.push_back(mk(1'b1, 4'h3, 32'h2100, 32'hA5A5_A5A5));
    run(10);
    check_int("to_cyc_cycles", n_cyc, 4);
    check("to_err_set", {68'd0, err}, 69'd1);
    nx_clr = 1'b1; run(1); nx_clr = 1'b0; run(1);
    check("to_err_cleared", {68'd0, err}, 69'd0);

    // Slave errors every attempt
    clr_mon(); mode = 2; delay = 0;
    exp_q.push_back(mk(1'b1, 4'h1, 32'h3000, 32'h1));
    exp_q.push_back(mk(1'b1, 4'h2, 32'h3004, 32'h2));
    run(16);
    check_int("err_pops", n_pop, 2);
    check_int("err_starts", n_starts, ERR_STARTS);
    check("err_set", {68'd0, err}, 69'd1);
    nx_clr = 1'b1; run(1); nx_clr = 1'b0; run(1);

    // Ack and err together count as ack
    clr_mon(); mode = 3; delay = 1;
    exp_q.push_back(mk(1'b1, 4'hF, 32'h4000, 32'h4));
    run(6);
    check_int("ackerr_starts", n_starts, 1);
    check("ackerr_no_err", {68'd0, err}, 69'd0);

    // Eight back-to-back zero-wait writes
    mode = 1; delay = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b1, 4'hF, 32'h5000 + 32'(4 * i), $urandom));
    clr_mon();
    run(16);
    check_int("b2b_pops", n_pop, 8);
    check_int("b2b_starts", n_starts, 8);
    check_int("b2b_fifo_left", exp_q.size(), 0);
    run(2);

    // Reset in the middle of a bus cycle
    mode = 0;
    exp_q.push_back(mk(1'b0, 4'hF, 32'h6000, 32'h0));
    waited = 0;
    while (!wb_cyc && waited < 10) begin cycle(); waited++; end
    check_int("wait_cyc_bounded", (waited < 10) ? 1 : 0, 1);
    run(1);
    clr_mon();
    nx_rst_n = 1'b0; run(2);
    check("rst_mid_cyc", {68'd0, wb_cyc}, 69'd0);
    check("rst_mid_busy", {68'd0, busy}, 69'd0);
    nx_rst_n = 1'b1; run(3);
    check_int("rst_mid_no_pop", n_pop, 0);
    check_int("rst_mid_no_rdv", n_rdv, 0);

    // Randomized traffic against the model
    mode = 4; rand_gap = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() < 4 && $urandom_range(0, 1) == 1)
        exp_q.push_back({1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom});
      nx_clr = ($urandom_range(0, 9) == 0);
      nx_rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    nx_rst_n = 1'b1; nx_clr = 1'b0; mode = 1; delay = 0; rand_gap = 1'b0;
    waited = 0;
    while ((exp_q.size() > 0 || busy) && waited < 100) begin cycle(); waited++; end
    check_int("drain_bounded", (waited < 100) ? 1 : 0, 1);
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zap_wb_fifo_drain.md
ZAP_WB_FIFO_DRAIN -- requirements
Module: zap_wb_fifo_drain

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles a bus cycle waits for ack/err before abort (1..65535).
REQ-002 SHALL have parameter MAX_RETRY, default 3, meaning reissues after i_wb_err (used only with the Configuration macro).
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_fifo_data  input  69  FWFT FIFO head: [68] we, [67:64] sel, [63:32] adr, [31:0] dat.
REQ-006 SHALL have port i_fifo_empty_n  input  1  head valid.
REQ-007 SHALL have port o_fifo_ack  output  1  pop strobe to the FIFO.
REQ-008 SHALL have ports o_wb_cyc/o_wb_stb/o_wb_we  output  1 each; o_wb_sel  output  4; o_wb_adr/o_wb_dat  output  32 each; o_wb_cti  output  3  Wishbone B3 master.
REQ-009 SHALL have ports i_wb_ack/i_wb_err  input  1 each; i_wb_dat  input  32.
REQ-010 SHALL have ports o_rd_data  output  32  and o_rd_valid  output  1  read return.
REQ-011 SHALL have ports o_busy  output  1, o_err  output  1 (sticky error) and i_err_clr  input  1.

Function
REQ-012 SHALL implement states IDLE, BUS, RETRY (RETRY reachable only with macro).
REQ-013 IDLE with i_fifo_empty_n=1 SHALL capture i_fifo_data into an entry register, pulse o_fifo_ack for exactly one cycle and move to BUS next cycle.
REQ-014 IDLE SHALL never pop when i_fifo_empty_n=0; o_fifo_ack SHALL never be high outside IDLE.
REQ-015 BUS SHALL hold o_wb_cyc=o_wb_stb=1 with we/sel/adr/dat from the entry register, stable until termination; o_wb_cti SHALL be 3'b111 always.
REQ-016 Termination: i_wb_ack, i_wb_err, or timeout counter equal to TIMEOUT; ack SHALL have priority over err, err over timeout.
REQ-017 On termination cyc/stb SHALL drop the following cycle, state returns to IDLE (or RETRY); peak throughput = 1 transfer per 2 cycles.
REQ-018 Read (we=0) terminated by ack SHALL register i_wb_dat into o_rd_data and pulse o_rd_valid one cycle later; writes SHALL never pulse o_rd_valid.
REQ-019 Timeout counter SHALL clear on entry to BUS, increment each BUS cycle, saturate, width $clog2(TIMEOUT+1).
REQ-020 Timeout or final err SHALL drop the entry and set o_err; i_err_clr SHALL clear o_err; simultaneous set and clear SHALL leave o_err=1.
REQ-021 o_busy SHALL be 1 whenever state != IDLE.

Reset
REQ-022 i_reset_n=0 at any clock edge SHALL force IDLE and zero all outputs, counters and entry register; an in-flight bus cycle SHALL be abandoned without ack to the FIFO (entry already popped is lost).
REQ-023 First pop after reset release SHALL occur no earlier than the first edge with i_reset_n=1.

Configuration
REQ-024 Macro ZAP_WB_ERR_RETRY_EN defined: i_wb_err SHALL go to RETRY (cyc low one cycle) then reissue the same entry, up to MAX_RETRY reissues per entry, then drop and set o_err; retry count clears per entry; timeouts SHALL not retry.
REQ-025 Macro undefined: i_wb_err SHALL drop the entry immediately and set o_err; RETRY state and retry counter SHALL not be synthesised.

Structure
REQ-026 Package zap_wb_pkg SHALL hold entry field offsets/width (69), CTI constants and state encodings.
REQ-027 Timeout counter SHALL be sub-module zap_wb_timer (clear, enable, saturate, o_expired); all else inline.

Verification
REQ-028 Write: head {we=1,sel=F,adr=0x1000,dat=0xDEADBEEF}, ack 3 cycles after stb -> one pop, one bus cycle with those values, o_err=0.
REQ-029 Read: head {we=0,adr=0x2000}, ack with i_wb_dat=0x12345678 -> o_rd_valid one cycle, o_rd_data=0x12345678.
REQ-030 TIMEOUT=4, no ack -> cyc held exactly 4 cycles, dropped, o_err=1; i_err_clr -> o_err=0.
REQ-031 Macro on, MAX_RETRY=2, err on every attempt -> 3 bus cycles, same adr each, then o_err=1, next entry popped; macro off -> 1 cycle then o_err=1.
REQ-032 Ack and err same cycle -> treated as ack, o_err stays 0; 8 back-to-back entries with zero-wait ack -> 8 pops in 16 cycles in order.
REQ-033 i_reset_n low mid-BUS -> cyc/stb/o_busy 0 next edge, no extra pop, no o_rd_valid.
